// File: rtl/free_list_bitmap_32_pkg.sv
// free_list_pkg: shared sizes, slot types and bitmap helpers for free_list_bitmap_32
package free_list_pkg;
  localparam int NUM_ENTRIES = 32;
  localparam int IDX_W = 5;
  typedef logic [IDX_W-1:0] slot_idx_t;
  typedef logic [NUM_ENTRIES-1:0] slot_map_t;
  function automatic slot_idx_t lowest_zero(slot_map_t m);
    lowest_zero = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) if (!m[i]) lowest_zero = slot_idx_t'(i);
  endfunction
  function automatic logic [IDX_W:0] count_free(slot_map_t m);
    count_free = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) count_free += {{IDX_W{1'b0}}, ~m[i]};
  endfunction
endpackage

// File: rtl/free_list_bitmap_32_if.sv
// free_list_bitmap_32_if: alloc/free handshake bus; master = consumer, slave = allocator
interface free_list_bitmap_32_if;
  import free_list_pkg::*;
  logic alloc_req;
  logic alloc_valid;
  slot_idx_t alloc_idx;
  logic free_valid;
  slot_idx_t free_idx;
  logic [IDX_W:0] free_count;
  logic free_err;
  logic [31:0] alloc_stall_cnt;
  modport master (output alloc_req, free_valid, free_idx, input alloc_valid, alloc_idx, free_count, free_err, alloc_stall_cnt);
  modport slave (input alloc_req, free_valid, free_idx, output alloc_valid, alloc_idx, free_count, free_err, alloc_stall_cnt);
endinterface

// File: rtl/free_list_bitmap_32_decoder.sv
// index_decoder_32: binary slot index to one-hot map (en low -> all zeros); ports en, idx, onehot
module index_decoder_32
  import free_list_pkg::*;
(
  input  logic en,
  input  slot_idx_t idx,
  output slot_map_t onehot
);
  assign onehot = en ? slot_map_t'(1) << idx : '0;
endmodule

// File: rtl/free_list_bitmap_32.sv
// free_list_bitmap_32: 32-slot lowest-free allocator; ports clk, rst, flush, bus (slave: alloc/free handshake, free_count, free_err, alloc_stall_cnt); FREE_LIST_STALL_STATS_EN enables the stall counter
module free_list_bitmap_32
  import free_list_pkg::*;
#(
  parameter slot_map_t RESERVED_MASK = 32'h0000_0001
) (
  input logic clk,
  input logic rst,
  input logic flush,
  free_list_bitmap_32_if.slave bus
);
  localparam logic [IDX_W:0] RST_CNT = count_free(RESERVED_MASK);
  slot_map_t busy, busy_nx, grant_map, free_map;
  slot_idx_t alloc_idx;
  logic alloc_valid, free_err, grant, free_ok;
  logic [IDX_W:0] free_count;
  assign grant = alloc_valid && bus.alloc_req;
  // a slot granted this cycle is still clear in busy, so freeing it is caught as already-free
  assign free_ok = bus.free_valid && busy[bus.free_idx] && !RESERVED_MASK[bus.free_idx];
  index_decoder_32 u_grant (.en(grant), .idx(alloc_idx), .onehot(grant_map));
  index_decoder_32 u_free (.en(free_ok), .idx(bus.free_idx), .onehot(free_map));
  assign busy_nx = (busy | grant_map) & ~free_map;
  always_ff @(posedge clk)
    if (rst || flush) begin
      busy <= RESERVED_MASK;
      alloc_idx <= lowest_zero(RESERVED_MASK);
      alloc_valid <= RST_CNT != '0;
      free_count <= RST_CNT;
      free_err <= 1'b0;
    end else begin
      busy <= busy_nx;
      alloc_idx <= lowest_zero(busy_nx);
      alloc_valid <= ~&busy_nx;
      free_count <= free_count - {{IDX_W{1'b0}}, grant} + {{IDX_W{1'b0}}, free_ok};
      free_err <= bus.free_valid && !free_ok;
    end
  assign bus.alloc_idx = alloc_idx;
  assign bus.alloc_valid = alloc_valid;
  assign bus.free_count = free_count;
  assign bus.free_err = free_err;
`ifdef FREE_LIST_STALL_STATS_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clk)
    if (rst) stall_cnt <= '0;
    else if (bus.alloc_req && !alloc_valid && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
  assign bus.alloc_stall_cnt = stall_cnt;
`else
  assign bus.alloc_stall_cnt = '0;
`endif
`ifndef SYNTHESIS
  a_count: assert property (@(posedge clk) disable iff (rst) free_count == count_free(busy));
`endif
endmodule

// File: tb/tb_free_list_bitmap_32.sv
// tb_free_list_bitmap_32: scoreboard bench with a slot-array reference model for free_list_bitmap_32
module tb_free_list_bitmap_32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  free_list_bitmap_32_if bus_i ();
  free_list_bitmap_32 dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus_i));
  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int idx;
    int count;
    bit err;
    longint stall;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int errors = 0;
  bit in_use[32];
  bit [31:0] rmask = 32'h1;
  bit m_err;
  longint m_stall;

  function automatic int m_lowest();
    for (int i = 0; i < 32; i++) if (!in_use[i]) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) if (!in_use[i]) n++;
    return n;
  endfunction

  task automatic model_step(input bit rq, input bit fv, input int fi, input bit fl, input bit rs);
    int lo = m_lowest();
    bit avail = lo >= 0;
    bit grant = rq && avail;
    bit legal = fv && in_use[fi] && !rmask[fi] && !(grant && fi == lo);
`ifdef FREE_LIST_STALL_STATS_EN
    if (rs) m_stall = 0;
    else if (rq && !avail && m_stall < 64'hFFFF_FFFF) m_stall++;
`else
    m_stall = 0;
`endif
    if (rs || fl) begin
      for (int i = 0; i < 32; i++) in_use[i] = rmask[i];
      m_err = 0;
    end else begin
      if (grant) in_use[lo] = 1;
      if (legal) in_use[fi] = 0;
      m_err = fv && !legal;
    end
    q.push_back('{m_lowest() >= 0, m_lowest(), m_count(), m_err, m_stall});
  endtask

  task automatic cycle(input bit rq, input bit fv, input int fi, input bit fl, input bit rs);
    bus_i.alloc_req = rq;
    bus_i.free_valid = fv;
    bus_i.free_idx = 5'(fi);
    flush = fl;
    rst = rs;
    @(posedge clk);
    model_step(rq, fv, fi, fl, rs);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("alloc_valid", longint'(bus_i.alloc_valid), longint'(e.valid));
        if (e.valid) chk("alloc_idx", longint'(bus_i.alloc_idx), longint'(e.idx));
        chk("free_count", longint'(bus_i.free_count), longint'(e.count));
        chk("free_err", longint'(bus_i.free_err), longint'(e.err));
        chk("alloc_stall_cnt", longint'(bus_i.alloc_stall_cnt), e.stall);
      end
    end
  end

  initial begin
    bus_i.alloc_req = 0;
    bus_i.free_valid = 0;
    bus_i.free_idx = 0;
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 31; i++) cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 17, 0, 0);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 3, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 20, 0, 0);
    cycle(1, 1, m_lowest(), 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 4, 1, 0);
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 31),
            $urandom_range(0, 199) == 0, $urandom_range(0, 999) == 0);
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, 0 required", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
